// File: rtl/beta_rf_pkg.sv
// Shared types and constants for the Beta register file with load scoreboard.
package beta_rf_pkg;

   typedef enum logic [1:0] {
      DST_RC = 2'd0,
      DST_RB = 2'd1,
      DST_LP = 2'd2,
      DST_XP = 2'd3
   } dst_e;

   localparam int unsigned ZERO_IDX   = 0;
   localparam int unsigned XP_IDX_DEF = 1;
   localparam int unsigned LP_IDX_DEF = 31;

endpackage : beta_rf_pkg

// File: rtl/rf_scoreboard.sv
// Per-register busy bits tracking outstanding loads; set beats load-clear beats W-clear.
module rf_scoreboard
   import beta_rf_pkg::*;
#(
   parameter  int unsigned NREG = 32,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            set_i,
   input  logic [AW-1:0]   set_addr_i,
   input  logic            ld_clr_i,
   input  logic [AW-1:0]   ld_addr_i,
   input  logic            w_clr_i,
   input  logic [AW-1:0]   w_addr_i,
   output logic [NREG-1:0] busy_o
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < int'(NREG); r++) begin
         if (set_i && (set_addr_i == AW'(r))) begin
            busy_d[r] = 1'b1;
         end else if (ld_clr_i && (ld_addr_i == AW'(r))) begin
            busy_d[r] = 1'b0;
         end else if (w_clr_i && (w_addr_i == AW'(r))) begin
            busy_d[r] = 1'b0;
         end
      end
      // Register 0 can never hold a pending load.
      busy_d[ZERO_IDX] = 1'b0;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;

endmodule : rf_scoreboard

// File: rtl/beta_regfile_sb.sv
// Beta register file: W (writeback) and L (load return) write ports, load scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data onto the read ports.
module beta_regfile_sb
   import beta_rf_pkg::*;
#(
   parameter  int unsigned WIDTH  = 32,
   parameter  int unsigned NREG   = 32,
   parameter  int unsigned XP_IDX = XP_IDX_DEF,
   parameter  int unsigned LP_IDX = LP_IDX_DEF,
   localparam int unsigned AW     = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    ra,
   input  logic [AW-1:0]    rb,
   input  logic [AW-1:0]    rc,
   input  logic             wr_en,
   input  logic [1:0]       wr_dst,
   input  logic [WIDTH-1:0] wdata,
   input  logic             ld_we,
   input  logic [AW-1:0]    ld_addr,
   input  logic [WIDTH-1:0] ld_data,
   input  logic             sb_set,
   input  logic [AW-1:0]    sb_addr,
   output logic [WIDTH-1:0] radata,
   output logic [WIDTH-1:0] rbdata,
   output logic             ra_busy,
   output logic             rb_busy,
   output logic             stall
);

   logic [WIDTH-1:0] mem_q [NREG];
   logic [WIDTH-1:0] mem_d [NREG];
   logic [AW-1:0]    w_addr;
   logic             w_act;
   logic             l_act;
   logic [NREG-1:0]  busy;

   // Port W destination select.
   always_comb begin
      w_addr = rc;
      case (dst_e'(wr_dst))
         DST_RC:  w_addr = rc;
         DST_RB:  w_addr = rb;
         DST_LP:  w_addr = AW'(LP_IDX);
         DST_XP:  w_addr = AW'(XP_IDX);
         default: w_addr = rc;
      endcase
   end

   assign w_act = wr_en && (w_addr != AW'(ZERO_IDX));
   assign l_act = ld_we && (ld_addr != AW'(ZERO_IDX));

   // W is applied after L so it wins a same-register collision.
   always_comb begin
      mem_d = mem_q;
      if (l_act) begin
         mem_d[ld_addr] = ld_data;
      end
      if (w_act) begin
         mem_d[w_addr] = wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NREG); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   rf_scoreboard #(
      .NREG (NREG)
   ) u_scoreboard (
      .clk_i      (clk),
      .reset_i    (reset),
      .set_i      (sb_set),
      .set_addr_i (sb_addr),
      .ld_clr_i   (ld_we),
      .ld_addr_i  (ld_addr),
      .w_clr_i    (w_act),
      .w_addr_i   (w_addr),
      .busy_o     (busy)
   );

   always_comb begin
      radata  = (ra == AW'(ZERO_IDX)) ? '0 : mem_q[ra];
      rbdata  = (rb == AW'(ZERO_IDX)) ? '0 : mem_q[rb];
      ra_busy = busy[ra];
      rb_busy = busy[rb];
`ifdef RF_BYPASS_EN
      if (ra != AW'(ZERO_IDX)) begin
         if (w_act && (w_addr == ra)) begin
            radata = wdata;
         end else if (l_act && (ld_addr == ra)) begin
            radata = ld_data;
         end
         if (l_act && (ld_addr == ra)) begin
            ra_busy = 1'b0;
         end
      end
      if (rb != AW'(ZERO_IDX)) begin
         if (w_act && (w_addr == rb)) begin
            rbdata = wdata;
         end else if (l_act && (ld_addr == rb)) begin
            rbdata = ld_data;
         end
         if (l_act && (ld_addr == rb)) begin
            rb_busy = 1'b0;
         end
      end
`endif
      stall = ra_busy | rb_busy;
   end

endmodule : beta_regfile_sb

// File: tb/tb_beta_regfile_sb.sv
// Directed self-checking bench for beta_regfile_sb (default 32x32 configuration).
module tb_beta_regfile_sb;
   import beta_rf_pkg::*;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned NREG  = 32;
   localparam int unsigned AW    = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic [AW-1:0]    ra, rb, rc;
   logic             wr_en;
   logic [1:0]       wr_dst;
   logic [WIDTH-1:0] wdata;
   logic             ld_we;
   logic [AW-1:0]    ld_addr;
   logic [WIDTH-1:0] ld_data;
   logic             sb_set;
   logic [AW-1:0]    sb_addr;
   logic [WIDTH-1:0] radata, rbdata;
   logic             ra_busy, rb_busy, stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   beta_regfile_sb #(
      .WIDTH (WIDTH),
      .NREG  (NREG)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .ra      (ra),
      .rb      (rb),
      .rc      (rc),
      .wr_en   (wr_en),
      .wr_dst  (wr_dst),
      .wdata   (wdata),
      .ld_we   (ld_we),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .sb_set  (sb_set),
      .sb_addr (sb_addr),
      .radata  (radata),
      .rbdata  (rbdata),
      .ra_busy (ra_busy),
      .rb_busy (rb_busy),
      .stall   (stall)
   );

   task automatic idle();
      wr_en  = 1'b0;
      ld_we  = 1'b0;
      sb_set = 1'b0;
   endtask

   // Commit currently driven inputs at the next posedge, then settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; ra = 5'd5; rb = 5'd7; rc = 5'd0; wr_dst = 2'(DST_RC);
      wdata = '0; ld_addr = '0; ld_data = '0; sb_addr = '0;
      idle();
      #1;
      checks++; if (radata !== 32'h0) begin errors++; $display("FAIL reset_radata got=%h exp=%h", radata, 32'h0); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
      tick();
      reset = 1'b0;
      wr_en = 1'b1; wr_dst = 2'(DST_RC); rc = 5'd5; wdata = 32'hDEAD;
      sb_set = 1'b1; sb_addr = 5'd7;
      tick();
      idle();
      ra = 5'd5; rb = 5'd7; #1;
      checks++; if (radata !== 32'hDEAD) begin errors++; $display("FAIL pre_reset_r5 got=%h exp=%h", radata, 32'hDEAD); end
      checks++; if (rb_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy7 got=%b exp=1", rb_busy); end
      // Asynchronous pulse between clock edges.
      #2 reset = 1'b1; #1;
      ra = 5'd5; #1;
      checks++; if (radata !== 32'h0) begin errors++; $display("FAIL mid_reset_r5 got=%h exp=0", radata); end
      ra = 5'd7; #1;
      checks++; if (ra_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy7 got=%b exp=0", ra_busy); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_reset_stall got=%b exp=0", stall); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_dest_mux();
      logic [AW-1:0] exp_reg [4];
      exp_reg[0] = 5'd4; exp_reg[1] = 5'd6; exp_reg[2] = 5'd31; exp_reg[3] = 5'd1;
      wr_en = 1'b1; wdata = 32'h11; rc = 5'd4; rb = 5'd6;
      for (int d = 0; d < 4; d++) begin
         wr_dst = 2'(d);
         tick();
      end
      idle();
      for (int d = 0; d < 4; d++) begin
         ra = exp_reg[d]; #1;
         checks++; if (radata !== 32'h11) begin errors++; $display("FAIL dest_mux_%0d r%0d got=%h exp=%h", d, exp_reg[d], radata, 32'h11); end
      end
      ra = 5'd2; #1;
      checks++; if (radata !== 32'h0) begin errors++; $display("FAIL dest_mux_r2_untouched got=%h exp=0", radata); end
   endtask

   task automatic test_zero_reg();
      wr_en = 1'b1; wr_dst = 2'(DST_RC); rc = 5'd0; wdata = 32'hFFFF;
      ld_we = 1'b1; ld_addr = 5'd0; ld_data = 32'h1234;
      sb_set = 1'b1; sb_addr = 5'd0;
      tick();
      idle();
      ra = 5'd0; rb = 5'd0; #1;
      checks++; if (radata !== 32'h0) begin errors++; $display("FAIL zero_ra got=%h exp=0", radata); end
      checks++; if (rbdata !== 32'h0) begin errors++; $display("FAIL zero_rb got=%h exp=0", rbdata); end
      checks++; if (ra_busy !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b exp=0", ra_busy); end
   endtask

   task automatic test_scoreboard();
      sb_set = 1'b1; sb_addr = 5'd9;
      tick();
      idle();
      rb = 5'd9; ra = 5'd4; #1;
      checks++; if (rb_busy !== 1'b1) begin errors++; $display("FAIL sb_rb_busy got=%b exp=1", rb_busy); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall got=%b exp=1", stall); end
      checks++; if (ra_busy !== 1'b0) begin errors++; $display("FAIL sb_ra_busy got=%b exp=0", ra_busy); end
      ld_we = 1'b1; ld_addr = 5'd9; ld_data = 32'h42;
      tick();
      idle(); #1;
      checks++; if (rbdata !== 32'h42) begin errors++; $display("FAIL sb_ld_data got=%h exp=%h", rbdata, 32'h42); end
      checks++; if (rb_busy !== 1'b0) begin errors++; $display("FAIL sb_ld_clear got=%b exp=0", rb_busy); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_ld_stall got=%b exp=0", stall); end
   endtask

   task automatic test_collision();
      sb_set = 1'b1; sb_addr = 5'd3;
      tick();
      idle();
      wr_en = 1'b1; wr_dst = 2'(DST_RC); rc = 5'd3; wdata = 32'hA;
      ld_we = 1'b1; ld_addr = 5'd3; ld_data = 32'hB;
      tick();
      idle();
      ra = 5'd3; #1;
      checks++; if (radata !== 32'hA) begin errors++; $display("FAIL collide_data got=%h exp=%h", radata, 32'hA); end
      checks++; if (ra_busy !== 1'b0) begin errors++; $display("FAIL collide_busy got=%b exp=0", ra_busy); end
   endtask

   task automatic test_priority();
      // Set beats a same-cycle load clear.
      sb_set = 1'b1; sb_addr = 5'd12; ld_we = 1'b1; ld_addr = 5'd12; ld_data = 32'h5;
      tick();
      idle();
      ra = 5'd12; #1;
      checks++; if (ra_busy !== 1'b1) begin errors++; $display("FAIL prio_set_busy got=%b exp=1", ra_busy); end
      checks++; if (radata !== 32'h5) begin errors++; $display("FAIL prio_set_data got=%h exp=5", radata); end
      // Younger W result clears a pending load (WAW).
      wr_en = 1'b1; wr_dst = 2'(DST_RC); rc = 5'd12; wdata = 32'h55;
      tick();
      idle(); #1;
      checks++; if (ra_busy !== 1'b0) begin errors++; $display("FAIL waw_busy got=%b exp=0", ra_busy); end
      checks++; if (radata !== 32'h55) begin errors++; $display("FAIL waw_data got=%h exp=%h", radata, 32'h55); end
      // Load to a non-busy register still writes.
      ld_we = 1'b1; ld_addr = 5'd20; ld_data = 32'hC0DE;
      tick();
      idle();
      ra = 5'd20; #1;
      checks++; if (radata !== 32'hC0DE) begin errors++; $display("FAIL ld_notbusy got=%h exp=%h", radata, 32'hC0DE); end
   endtask

   task automatic test_bypass();
      logic [WIDTH-1:0] exp_data;
      logic             exp_busy;
      sb_set = 1'b1; sb_addr = 5'd9;
      tick();
      idle();
      ld_we = 1'b1; ld_addr = 5'd9; ld_data = 32'h77; ra = 5'd9; #1;
`ifdef RF_BYPASS_EN
      exp_data = 32'h77; exp_busy = 1'b0;
`else
      exp_data = 32'h42; exp_busy = 1'b1;
`endif
      checks++; if (radata !== exp_data) begin errors++; $display("FAIL bypass_data got=%h exp=%h", radata, exp_data); end
      checks++; if (ra_busy !== exp_busy) begin errors++; $display("FAIL bypass_busy got=%b exp=%b", ra_busy, exp_busy); end
      tick();
      idle(); #1;
      checks++; if (radata !== 32'h77) begin errors++; $display("FAIL bypass_after_data got=%h exp=%h", radata, 32'h77); end
      checks++; if (ra_busy !== 1'b0) begin errors++; $display("FAIL bypass_after_busy got=%b exp=0", ra_busy); end
   endtask

   initial begin
      test_reset();
      test_dest_mux();
      test_zero_reg();
      test_scoreboard();
      test_collision();
      test_priority();
      test_bypass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_beta_regfile_sb
